// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripheral block.
//   - state_t            : states of the TX arbiter FSM
//   - UART_*_ADDR        : memory-mapped register addresses of the UART
//   - DEFAULT_BUSY_TIMEOUT : cycles allowed between tx_start and tx_busy rising
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
    localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
    localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

    localparam int DEFAULT_BUSY_TIMEOUT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   req_i         : request vector
//   accept_i      : strobe; the current winner was taken this edge
//   grant_o       : one-hot winner (all zeros when no request)
//   grant_idx_o   : index of the winner
//   any_o         : at least one request is pending
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               accept_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    // Scan upward from the pointer, wrapping, and stop at the first request.
    // The wrap is a subtraction so NUM_REQ need not be a power of two.
    always_comb begin
        int  idx;
        logic found;
        idx         = 0;
        found       = 1'b0;
        grant_o     = '0;
        grant_idx_o = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = IDX_W'(idx);
            end
        end
        any_o = found;
    end

    // Pointer moves to just past the winner so it becomes lowest priority.
    always_comb begin
        if (int'(grant_idx_o) == NUM_REQ - 1) begin
            ptr_d = '0;
        end else begin
            ptr_d = grant_idx_o + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (accept_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   req_valid    : per-requester byte pending
//   req_data     : packed bytes, requester i at [i*DATA_W +: DATA_W]
//   req_ready    : one-hot accept, only ever asserted in IDLE
//   tx_start     : one-cycle start pulse to the TX core
//   tx_data      : byte to the TX core, held until the frame ends
//   tx_busy      : TX core is shifting a frame
//   tx_done      : TX core finished the stop bit
//   grant_id     : index of the current or last granted requester
//   busy         : arbiter is handling a frame
//   timeout_err  : one-cycle pulse when tx_busy never rose
//   sent_count   : completed frames, wrapping
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT,
    parameter int CNT_W        = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_busy,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err,
    output logic [CNT_W-1:0]           sent_count
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;
    logic [CNT_W-1:0]   sent_count_q, sent_count_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               timeout_err_q, timeout_err_d;
    logic               tx_busy_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               accept;

    // Grants are only taken in IDLE, so a request arriving with tx_done
    // waits for the following IDLE cycle.
    assign accept = (state_q == ST_IDLE) && arb_any && !reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_valid),
        .accept_i    (accept),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .any_o       (arb_any)
    );

    // Next-state and output decode. A frame ends either on tx_done or on a
    // falling tx_busy, whichever the TX core provides first; WAIT_BUSY also
    // accepts tx_done directly for frames too short to show tx_busy.
    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        grant_id_d    = grant_id_q;
        sent_count_d  = sent_count_q;
        timer_d       = timer_q;
        timeout_err_d = 1'b0;
        req_ready     = '0;
        tx_start      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!reset) begin
                    req_ready = arb_grant;
                end
                if (accept) begin
                    tx_data_d  = req_data[arb_idx*DATA_W +: DATA_W];
                    grant_id_d = arb_idx;
                    state_d    = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                tx_start = 1'b1;
                timer_d  = '0;
                state_d  = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tx_done) begin
                    sent_count_d = sent_count_q + CNT_W'(1);
                    state_d      = ST_IDLE;
                end else if (timer_q == TMR_W'(BUSY_TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done || (tx_busy_q && !tx_busy)) begin
                    sent_count_d = sent_count_q + CNT_W'(1);
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            tx_data_q     <= '0;
            grant_id_q    <= '0;
            sent_count_q  <= '0;
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
            tx_busy_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            grant_id_q    <= grant_id_d;
            sent_count_q  <= sent_count_d;
            timer_q       <= timer_d;
            timeout_err_q <= timeout_err_d;
            tx_busy_q     <= tx_busy;
        end
    end

    assign tx_data     = tx_data_q;
    assign grant_id    = grant_id_q;
    assign sent_count  = sent_count_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (NUM_REQ=2, BUSY_TIMEOUT=16, CNT_W=4).
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done;
    logic [0:0]  grant_id;
    logic        busy;
    logic        timeout_err;
    logic [3:0]  sent_count;

    int vectors     = 0;
    int miscompares = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (2),
        .DATA_W       (8),
        .BUSY_TIMEOUT (16),
        .CNT_W        (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err),
        .sent_count  (sent_count)
    );

    always #5 clk = ~clk;

    // Advance one clock and land 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive requester inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic [1:0] valid, input logic [7:0] d0,
                                 input logic [7:0] d1);
        req_valid = valid;
        req_data  = {d1, d0};
        #1;
    endtask

    // One complete frame starting from an IDLE sample point.
    task automatic doFrame(input logic [1:0] valid, input logic [7:0] d0,
                           input logic [7:0] d1, input logic [1:0] expReady,
                           input logic [7:0] expData, input logic expGrant,
                           input int busyCycles, input logic [3:0] expCount);
        applyStimulus(valid, d0, d1);
        checkOutput("ready_idle", req_ready, expReady);
        tick();
        checkOutput("tx_start_launch", tx_start, 1);
        checkOutput("tx_data_launch", tx_data, expData);
        checkOutput("grant_id_launch", grant_id, expGrant);
        checkOutput("ready_launch", req_ready, 0);
        tick();
        tx_busy = 1'b1;
        checkOutput("tx_start_one_cycle", tx_start, 0);
        checkOutput("ready_wait_busy", req_ready, 0);
        tick();
        for (int k = 0; k < busyCycles; k++) begin
            checkOutput("ready_wait_done", req_ready, 0);
            checkOutput("busy_wait_done", busy, 1);
            tick();
        end
        tx_done = 1'b1;
        tx_busy = 1'b0;
        tick();
        tx_done = 1'b0;
        checkOutput("busy_after_frame", busy, 0);
        checkOutput("sent_count_frame", sent_count, expCount);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_busy   = 1'b0;
        tx_done   = 1'b0;
        tick();
        tick();

        // Reset state, with requests pending that must not be acknowledged
        applyStimulus(2'b11, 8'h11, 8'h22);
        checkOutput("rst_ready", req_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_tx_start", tx_start, 0);
        checkOutput("rst_tx_data", tx_data, 0);
        checkOutput("rst_grant_id", grant_id, 0);
        checkOutput("rst_timeout", timeout_err, 0);
        checkOutput("rst_sent_count", sent_count, 0);
        req_valid = '0;
        reset     = 1'b0;
        tick();

        // Single request from requester 0
        doFrame(2'b01, 8'h2D, 8'h00, 2'b01, 8'h2D, 1'b0, 3, 4'd1);
        req_valid = '0;

        // Re-reset so round robin starts from pointer 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst2_sent_count", sent_count, 0);
        tick();

        // Both requesters continuously valid: alternate 0,1,0,1
        doFrame(2'b11, 8'hA5, 8'h3C, 2'b01, 8'hA5, 1'b0, 2, 4'd1);
        doFrame(2'b11, 8'hA5, 8'h3C, 2'b10, 8'h3C, 1'b1, 2, 4'd2);
        doFrame(2'b11, 8'hA5, 8'h3C, 2'b01, 8'hA5, 1'b0, 2, 4'd3);
        doFrame(2'b11, 8'hA5, 8'h3C, 2'b10, 8'h3C, 1'b1, 2, 4'd4);

        // tx_busy never rises: abort after 16 cycles in WAIT_BUSY
        applyStimulus(2'b01, 8'h11, 8'h22);
        checkOutput("to_ready", req_ready, 2'b01);
        tick();
        applyStimulus(2'b00, 8'h11, 8'h22);
        checkOutput("to_tx_start", tx_start, 1);
        tick();
        checkOutput("to_err_entry", timeout_err, 0);
        for (int k = 1; k < 16; k++) begin
            tick();
            checkOutput("to_err_early", timeout_err, 0);
            checkOutput("to_busy_early", busy, 1);
        end
        tick();
        checkOutput("to_err_pulse", timeout_err, 1);
        checkOutput("to_busy_idle", busy, 0);
        checkOutput("to_sent_count", sent_count, 4);
        tick();
        checkOutput("to_err_single", timeout_err, 0);

        // tx_done coincident with a new request from requester 1
        applyStimulus(2'b01, 8'h5A, 8'hC3);
        checkOutput("co_ready0", req_ready, 2'b01);
        tick();
        applyStimulus(2'b00, 8'h5A, 8'hC3);
        checkOutput("co_data0", tx_data, 8'h5A);
        tick();
        tx_busy = 1'b1;
        tick();
        tick();
        tx_done = 1'b1;
        tx_busy = 1'b0;
        applyStimulus(2'b10, 8'h5A, 8'hC3);
        checkOutput("co_no_early_ready", req_ready, 0);
        tick();
        tx_done = 1'b0;
        applyStimulus(2'b10, 8'h5A, 8'hC3);
        checkOutput("co_sent_count", sent_count, 5);
        checkOutput("co_busy", busy, 0);
        checkOutput("co_ready1", req_ready, 2'b10);
        tick();
        applyStimulus(2'b00, 8'h5A, 8'hC3);
        checkOutput("co_grant1", grant_id, 1);
        checkOutput("co_data1", tx_data, 8'hC3);
        tick();
        tx_busy = 1'b1;
        tick();
        tx_done = 1'b1;
        tx_busy = 1'b0;
        tick();
        tx_done = 1'b0;
        checkOutput("co_sent_count2", sent_count, 6);

        // Run the 4-bit frame counter up to 15 and across the wrap
        for (int i = 7; i <= 15; i++) begin
            doFrame(2'b01, 8'(i), 8'h00, 2'b01, 8'(i), 1'b0, 1, 4'(i));
        end
        checkOutput("wrap_at_15", sent_count, 15);
        doFrame(2'b01, 8'hEE, 8'h00, 2'b01, 8'hEE, 1'b0, 1, 4'd0);

        // Reset while in WAIT_DONE
        applyStimulus(2'b01, 8'h77, 8'h88);
        tick();
        applyStimulus(2'b00, 8'h77, 8'h88);
        tick();
        tx_busy = 1'b1;
        tick();
        checkOutput("rwd_busy_before", busy, 1);
        reset = 1'b1;
        tick();
        checkOutput("rwd_busy", busy, 0);
        checkOutput("rwd_tx_start", tx_start, 0);
        checkOutput("rwd_sent_count", sent_count, 0);
        checkOutput("rwd_grant_id", grant_id, 0);
        checkOutput("rwd_tx_data", tx_data, 0);
        reset   = 1'b0;
        tx_busy = 1'b0;
        tick();
        applyStimulus(2'b11, 8'h77, 8'h88);
        checkOutput("rwd_ptr_both", req_ready, 2'b01);
        applyStimulus(2'b10, 8'h77, 8'h88);
        checkOutput("rwd_ptr_req1_only", req_ready, 2'b10);
        applyStimulus(2'b00, 8'h77, 8'h88);
        tick();
        checkOutput("rwd_idle_final", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single peripheral UART transmitter between NUM_REQ byte sources, e.g. the CPU store path to the TX data register at 0x40000018 and a debug/echo source.
- Selects the winner round-robin, hands its byte to the transmitter with a one-cycle start pulse, and waits for the frame to complete before the next grant.
- Sits between the requesters and the UART TX core inside the peripheral block.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_W, 8, byte width sent per frame
BUSY_TIMEOUT, 16, cycles allowed from tx_start until tx_busy rises before aborting
CNT_W, 16, width of the sent-frame counter

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester byte pending
req_data  input  NUM_REQ*DATA_W  per-requester byte; requester i uses slice [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot accept; a byte transfers on the edge where valid & ready
tx_start  output  1  one-cycle pulse to the TX core
tx_data  output  DATA_W  byte to the TX core; held stable from LAUNCH through WAIT_DONE
tx_busy  input  1  TX core is shifting a frame
tx_done  input  1  one-cycle pulse at the end of the stop bit
grant_id  output  $clog2(NUM_REQ)  index of the current or last granted requester
busy  output  1  high in any state other than IDLE
timeout_err  output  1  one-cycle pulse on a BUSY_TIMEOUT abort
sent_count  output  CNT_W  frames completed; wraps

Behaviour:
- Reset (synchronous): the following all take effect at the first edge with reset=1.
  - Outputs: state=IDLE, req_ready=0, tx_start=0, tx_data=0, grant_id=0, busy=0, timeout_err=0, sent_count=0.
  - Internal: priority pointer=0.
  - Reset mid-frame abandons the frame; no ready pulse is issued for it.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - req_ready is combinational. It is one-hot on the winner when any req_valid=1; otherwise all zeros.
  - Winner = first set req_valid scanning from pointer upward, wrapping modulo NUM_REQ.
  - On the accept edge: latch the byte into tx_data, set grant_id=winner, set pointer=(winner+1) mod NUM_REQ, go to LAUNCH.
- LAUNCH: tx_start=1 for exactly this cycle; timeout counter cleared; go to WAIT_BUSY.
- WAIT_BUSY:
  - If tx_busy=1, go to WAIT_DONE.
  - If tx_done=1 (very short frame), count the frame and go to IDLE.
  - Otherwise, after BUSY_TIMEOUT cycles in this state, pulse timeout_err and go to IDLE; the frame is not counted.
- WAIT_DONE: on tx_done=1, or on tx_busy falling edge with no tx_done seen, sent_count += 1 and go to IDLE.
- Latency: valid in an IDLE cycle n gives ready in cycle n and tx_start in cycle n+1. Minimum 3 cycles per frame, excluding TX time.
- Simultaneous events:
  - tx_done and a new valid in the same cycle: the frame completes first, and the new request is arbitrated in the following IDLE cycle. No grant is issued outside IDLE.
  - A requester dropping valid before ready is not committed; no data is captured.
- Requester data must stay stable while valid=1 and ready=0.
- sent_count wraps from 2^CNT_W-1 to 0 silently.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum;
  - UART register address constants: TXD 0x40000018, RXD 0x4000001C, CON 0x40000020;
  - default BUSY_TIMEOUT.
- One sub-module, rr_arbiter, is natural. It is combinational one-hot winner selection from (req, pointer) plus the registered pointer update on an accept strobe. The parent FSM instantiates it once.

Test Plan:
- Single request: req_valid=01, data0=0x2D, at the IDLE cycle.
  -> req_ready=01 in that cycle; tx_start pulse next cycle with tx_data=0x2D; after TX model tx_done, sent_count=1 and busy=0.
- Both requesters continuously valid, data0=0xA5, data1=0x3C, for 4 frames.
  -> grant_id sequence 0,1,0,1; tx_data sequence A5,3C,A5,3C; each req_ready is exactly one cycle per frame.
- tx_busy held 0 after tx_start.
  -> timeout_err pulses once exactly BUSY_TIMEOUT cycles after entering WAIT_BUSY; state returns to IDLE; sent_count unchanged.
- tx_done coincident with req_valid=10 arriving.
  -> sent_count increments that edge; req_ready=10 asserted in the next IDLE cycle, not earlier.
- reset=1 asserted during WAIT_DONE.
  -> next cycle busy=0, tx_start=0, sent_count=0, pointer=0; a pending req1 is then granted ahead of req0 only if req0 is not valid.
- sent_count preloaded near wrap (CNT_W=4, 15 frames, then one more).
  -> count reads 15 then 0.
